// File: rtl/multiprecision_add_seq.sv
// Byte-serial multiprecision add/subtract sequencer driving a shared 8-bit adder,
// plus the 8-bit Kogge-Stone adder it is normally paired with.

module kogge_stone_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] sum,
    output logic       co
);
    logic [7:0] p0, g0, g1, g2, g3;
    logic [7:2] p1;
    logic [7:4] p2;

    // Carry-in folded into bit 0 generate so every prefix already includes it
    assign p0 = a ^ b;
    assign g0 = (a & b) | {7'b0, p0[0] & ci};

    for (genvar i = 0; i < 8; i++) begin : g_lvl1
        if (i >= 1) begin : g_op
            assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
        end else begin : g_pass
            assign g1[i] = g0[i];
        end
        if (i >= 2) begin : g_p
            assign p1[i] = p0[i] & p0[i-1];
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_lvl2
        if (i >= 2) begin : g_op
            assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
        end else begin : g_pass
            assign g2[i] = g1[i];
        end
        if (i >= 4) begin : g_p
            assign p2[i] = p1[i] & p1[i-2];
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_lvl3
        if (i >= 4) begin : g_op
            assign g3[i] = g2[i] | (p2[i] & g2[i-4]);
        end else begin : g_pass
            assign g3[i] = g2[i];
        end
    end

    assign sum = p0 ^ {g3[6:0], ci};
    assign co  = g3[7];
endmodule

module multiprecision_add_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    output logic             add_ci,
    input  logic [7:0]       add_sum,
    input  logic             add_co,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);
    localparam int NBYTES = WIDTH / 8;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sub_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        sub_reg <= sub;
                        idx     <= '0;
                        // Subtraction is A + ~B + 1: the +1 enters as the first carry-in
                        carry   <= sub;
                        result  <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    result[8*idx +: 8] <= add_sum;
                    carry              <= add_co;
                    if (idx == LAST) begin
                        carry_out <= add_co;
                        state     <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        if (state == S_RUN) begin
            add_a  = a_reg[8*idx +: 8];
            add_b  = b_reg[8*idx +: 8] ^ {8{sub_reg}};
            add_ci = carry;
        end
    end

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);
endmodule
